move_selector: RTL and testbench
================================

MOVE_SELECTOR -- requirements
Module: move_selector

Interface
REQ-001 SHALL have parameter BOARD_CELLS, default 225, meaning the number of cells on the 15x15 board.
REQ-002 SHALL have parameter SCORE_W, default 32, meaning the score width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit: a one-cycle pulse that requests a search.
REQ-007 SHALL have port i_board, input, board_t (225 x 2 bits): the position, sampled on i_start.
REQ-008 SHALL have port i_turn, input, 1 bit: side to move (0 black, 1 white), sampled on i_start.
REQ-009 SHALL have port o_sc_start, output, 1 bit: start pulse to the scorer.
REQ-010 SHALL have port o_sc_board, output, board_t: trial board sent to the scorer.
REQ-011 SHALL have port o_sc_turn, output, 1 bit: latched turn sent to the scorer.
REQ-012 SHALL have port i_sc_score, input, SCORE_W bits: scorer result, unsigned.
REQ-013 SHALL have port i_sc_finish, input, 1 bit: scorer done pulse.
REQ-014 SHALL have port o_move, output, 8 bits: chosen cell index (row*15+col).
REQ-015 SHALL have port o_best_score, output, SCORE_W bits: score of the chosen move.
REQ-016 SHALL have port o_busy, output, 1 bit: high while a search is in progress.
REQ-017 SHALL have port o_finish, output, 1 bit: one-cycle pulse when a result is valid.

Function
REQ-018 Cell encoding SHALL be: 0 empty, 1 black, 2 white, 3 illegal (treated as occupied).
REQ-019 FSM SHALL have states IDLE, SCAN, ISSUE, WAIT, CMP and DONE.
REQ-020 On i_start in IDLE: latch board and turn, set idx=0, best_score=0, best_move=8'hFF, then go to SCAN.
REQ-021 SCAN SHALL test one index per cycle; an index that is a candidate goes to ISSUE, otherwise idx increments; when idx passes 224, go to DONE.
REQ-022 A candidate SHALL be an empty cell.
REQ-023 In ISSUE: o_sc_board = latched board with cell idx set to 1+turn; assert o_sc_start for exactly one cycle; go to WAIT.
REQ-024 o_sc_board SHALL stay stable from ISSUE until i_sc_finish is seen.
REQ-025 WAIT SHALL hold until i_sc_finish=1, capture i_sc_score that same cycle, then go to CMP.
REQ-026 CMP SHALL replace best only if score > best_score, or if best_move==8'hFF; ties keep the lower index. Then idx increments and the FSM returns to SCAN.
REQ-027 DONE SHALL drive o_move and o_best_score, pulse o_finish for one cycle, and return to IDLE.
REQ-028 Outputs SHALL hold their values until the next i_start.
REQ-029 If there are no candidates, DONE SHALL give o_move=8'hFF and o_best_score=0.
REQ-030 i_start while o_busy=1 SHALL be ignored; o_busy is high in every state except IDLE.
REQ-031 An i_sc_finish outside WAIT SHALL be ignored.
REQ-032 Latency SHALL be 227 + sum over candidates of (scorer latency + 3) cycles, ±1.

Reset
REQ-033 i_rst SHALL force IDLE from any state, including mid-WAIT; the scorer result in flight is then discarded.
REQ-034 Reset values SHALL be: o_sc_start=0, o_finish=0, o_busy=0, o_move=8'hFF, o_best_score=0, o_sc_turn=0, o_sc_board all-empty.

Configuration
REQ-035 Macro MOVE_SEL_NEIGHBOR_EN SHALL control a neighbour filter.
REQ-036 When MOVE_SEL_NEIGHBOR_EN is defined, a candidate SHALL also need an occupied cell at Chebyshev distance 1, without wrap across rows or board edges.
REQ-037 When MOVE_SEL_NEIGHBOR_EN is defined and no filtered candidate exists, centre cell 112 SHALL be evaluated if empty.
REQ-038 When MOVE_SEL_NEIGHBOR_EN is undefined, every empty cell SHALL be a candidate and the filter logic SHALL be absent.

Structure
REQ-039 gobang_pkg SHALL hold: cell_t, board_t, BOARD_DIM=15, BOARD_CELLS=225, CELL_EMPTY, CELL_BLACK, CELL_WHITE, NO_MOVE=8'hFF.
REQ-040 There SHALL be one combinational sub-module, neighbor_check (board, idx -> has_neighbor), instantiated only under MOVE_SEL_NEIGHBOR_EN.
REQ-041 The scorer SHALL be external; move_selector SHALL not instantiate it.

Verification
REQ-042 Bench scorer model SHALL return the count of own stones in the row of the placed stone, with 3-cycle latency.
REQ-043 Full board except cells 7 and 200, black to move -> exactly 2 o_sc_start pulses; o_move is the higher-scoring cell; one o_finish pulse.
REQ-044 Board fully occupied -> no o_sc_start; o_move=8'hFF, o_best_score=0; o_finish within 230 cycles.
REQ-045 Model returns constant 5 for every cell -> o_move is the first empty index (tie rule).
REQ-046 i_rst asserted during WAIT with i_sc_finish arriving 1 cycle later -> FSM in IDLE, o_finish never pulses, outputs equal reset values.
REQ-047 Second i_start mid-search plus a stray i_sc_finish in SCAN -> both ignored; result identical to the undisturbed run.
REQ-048 With MOVE_SEL_NEIGHBOR_EN defined: empty board -> only cell 112 evaluated, o_move=112; single stone at 0 -> candidates exactly {1,15,16}.

Source files
------------

// File: rtl/gobang_pkg.sv
// Shared types and constants for the gobang move search.
// Holds the cell encoding, the packed board type, board geometry, the
// "no move" marker and the move_selector FSM state type.
package gobang_pkg;

  localparam int BOARD_DIM   = 15;
  localparam int BOARD_CELLS = 225;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY   = 2'd0;
  localparam cell_t CELL_BLACK   = 2'd1;
  localparam cell_t CELL_WHITE   = 2'd2;
  localparam cell_t CELL_ILLEGAL = 2'd3;

  // Cell i lives at board[i], i = row*BOARD_DIM + col.
  typedef cell_t [BOARD_CELLS-1:0] board_t;

  localparam logic [7:0] NO_MOVE     = 8'hFF;
  localparam logic [7:0] CENTER_CELL = 8'd112;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_CMP, S_DONE
  } state_t;

  // Stone colour placed by the side to move (0 black, 1 white).
  function automatic cell_t stone_of(input logic turn);
    return turn ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/move_selector_neighbor_check.sv
// neighbor_check: combinational test for an occupied cell at Chebyshev
// distance 1 from cell idx. Neighbours off the board edges are skipped
// (no wrap between rows). Illegal cells count as occupied.
// Ports:
//   board        - position under test
//   idx          - cell index (row*15+col), expected < 225
//   has_neighbor - 1 when any of the up to 8 surrounding cells is non-empty
module neighbor_check
  import gobang_pkg::*;
(
  input  board_t     board,
  input  logic [7:0] idx,
  output logic       has_neighbor
);

  int row, col, r, c;

  always_comb begin
    has_neighbor = 1'b0;
    row = int'(idx) / BOARD_DIM;
    col = int'(idx) % BOARD_DIM;
    r   = 0;
    c   = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = row + dr;
        c = col + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < BOARD_DIM &&
            c >= 0 && c < BOARD_DIM) begin
          if (board[r*BOARD_DIM + c] != CELL_EMPTY) has_neighbor = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/move_selector.sv
// move_selector: sequential one-ply move search for gobang.
// Scans the latched board one cell per cycle; each candidate (empty cell)
// is placed on a trial board, handed to an external scorer, and the result
// compared against the running best. Ties keep the lower index.
// Optional feature macro: MOVE_SEL_NEIGHBOR_EN -- candidates must also touch
// an occupied cell; if none qualify, the centre cell is tried when empty.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_start, i_board, i_turn - search request and position (sampled in IDLE)
//   o_sc_start/board/turn   - request to the external scorer
//   i_sc_score, i_sc_finish - scorer response (only honoured in WAIT)
//   o_move, o_best_score    - result, held until the next search completes
//   o_busy, o_finish        - search in progress / one-cycle result pulse
module move_selector #(
  parameter int BOARD_CELLS = 225,
  parameter int SCORE_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  gobang_pkg::board_t   i_board,
  input  logic                 i_turn,
  output logic                 o_sc_start,
  output gobang_pkg::board_t   o_sc_board,
  output logic                 o_sc_turn,
  input  logic [SCORE_W-1:0]   i_sc_score,
  input  logic                 i_sc_finish,
  output logic [7:0]           o_move,
  output logic [SCORE_W-1:0]   o_best_score,
  output logic                 o_busy,
  output logic                 o_finish
);
  import gobang_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(BOARD_CELLS - 1);
  localparam logic [7:0] END_IDX  = 8'(BOARD_CELLS);

  state_t               state, next_state;
  board_t               board_q, trial;
  logic [7:0]           idx, trial_idx, best_move;
  logic [SCORE_W-1:0]   best_score, score_q;
  logic                 idx_in, scan_end, is_empty, cand, fallback_go;

  assign idx_in   = (idx <= LAST_IDX);
  assign scan_end = !idx_in;
  assign is_empty = idx_in && (board_q[idx] == CELL_EMPTY);

`ifdef MOVE_SEL_NEIGHBOR_EN
  logic has_nb, found, fallback_used;

  neighbor_check u_nbr (
    .board        (board_q),
    .idx          (idx),
    .has_neighbor (has_nb)
  );

  assign cand = is_empty && has_nb;
  // Nothing passed the filter: give the centre one evaluation.
  assign fallback_go = scan_end && !found && !fallback_used &&
                       (board_q[CENTER_CELL] == CELL_EMPTY);
`else
  assign cand        = is_empty;
  assign fallback_go = 1'b0;
`endif

  assign trial_idx = fallback_go ? CENTER_CELL : idx;

  always_comb begin
    trial = board_q;
    if (trial_idx <= LAST_IDX) trial[trial_idx] = stone_of(o_sc_turn);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_start) next_state = S_SCAN;
      S_SCAN: begin
        if (scan_end)  next_state = fallback_go ? S_ISSUE : S_DONE;
        else if (cand) next_state = S_ISSUE;
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (i_sc_finish) next_state = S_CMP;
      S_CMP:   next_state = S_SCAN;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign o_busy   = (state != S_IDLE);
  assign o_finish = (state == S_DONE);

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      board_q      <= '0;
      o_sc_turn    <= 1'b0;
      o_sc_board   <= '0;
      o_sc_start   <= 1'b0;
      idx          <= '0;
      best_move    <= NO_MOVE;
      best_score   <= '0;
      score_q      <= '0;
      o_move       <= NO_MOVE;
      o_best_score <= '0;
`ifdef MOVE_SEL_NEIGHBOR_EN
      found         <= 1'b0;
      fallback_used <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          board_q    <= i_board;
          o_sc_turn  <= i_turn;
          idx        <= '0;
          best_move  <= NO_MOVE;
          best_score <= '0;
`ifdef MOVE_SEL_NEIGHBOR_EN
          found         <= 1'b0;
          fallback_used <= 1'b0;
`endif
        end
        S_SCAN: begin
          if (scan_end) begin
            if (fallback_go) begin
              idx        <= CENTER_CELL;
              o_sc_board <= trial;
              o_sc_start <= 1'b1;
`ifdef MOVE_SEL_NEIGHBOR_EN
              fallback_used <= 1'b1;
`endif
            end else begin
              o_move       <= best_move;
              o_best_score <= best_score;
            end
          end else if (cand) begin
            // Trial board is frozen here and held until the next candidate.
            o_sc_board <= trial;
            o_sc_start <= 1'b1;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        S_ISSUE: o_sc_start <= 1'b0;
        S_WAIT:  if (i_sc_finish) score_q <= i_sc_score;
        S_CMP: begin
          if (score_q > best_score || best_move == NO_MOVE) begin
            best_move  <= idx;
            best_score <= score_q;
          end
`ifdef MOVE_SEL_NEIGHBOR_EN
          found <= 1'b1;
          // After the centre fallback jump straight past the board.
          idx   <= fallback_used ? END_IDX : idx + 8'd1;
`else
          idx   <= idx + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_selector.sv
// Scoreboard bench for move_selector with an in-bench scorer model
// (own stones in the placed stone's row, 3-cycle latency) and a reference
// search model. Optional macro MOVE_SEL_NEIGHBOR_EN enables filter tests.
module tb_move_selector;
  import gobang_pkg::*;

  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst, start, turn;
  board_t        board, sc_board;
  logic          sc_start, sc_turn, sc_finish;
  logic [SW-1:0] sc_score;
  logic [7:0]    move;
  logic [SW-1:0] best;
  logic          busy, finish;

  logic          mdl_fin = 1'b0, stray_fin = 1'b0;
  logic [SW-1:0] mdl_score = '0;

  assign sc_finish = mdl_fin | stray_fin;
  assign sc_score  = stray_fin ? '1 : mdl_score;

  always #5 clk = ~clk;

  move_selector #(.BOARD_CELLS(225), .SCORE_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_board(board), .i_turn(turn),
    .o_sc_start(sc_start), .o_sc_board(sc_board), .o_sc_turn(sc_turn),
    .i_sc_score(sc_score), .i_sc_finish(sc_finish),
    .o_move(move), .o_best_score(best), .o_busy(busy), .o_finish(finish)
  );

  typedef struct { int move; int score; int starts; } exp_t;
  exp_t   exp_q[$];
  int     cand_q[$];
  int     n_chk = 0, n_fail = 0;
  int     nstarts = 0, nfin = 0;
  board_t ref_board;
  bit     ref_turn;
  bit     const5 = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int row_own(input board_t b, input int i, input bit t);
    int r = i / 15, cnt = 1;  // the stone being placed
    for (int c = 0; c < 15; c++)
      if (b[r*15+c] == (t ? CELL_WHITE : CELL_BLACK)) cnt++;
    return cnt;
  endfunction

  function automatic bit nb_occ(input board_t b, input int i);
    int r = i / 15, c = i % 15;
    for (int y = r - 1; y <= r + 1; y++)
      for (int x = c - 1; x <= c + 1; x++)
        if ((y != r || x != c) && y >= 0 && y < 15 && x >= 0 && x < 15 &&
            b[y*15+x] != CELL_EMPTY) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ref_eval(input board_t b, input bit t);
    int cands[$];
    int bm = 255, bs = 0, sc;
    for (int i = 0; i < 225; i++)
      if (b[i] == CELL_EMPTY) begin
`ifdef MOVE_SEL_NEIGHBOR_EN
        if (nb_occ(b, i)) cands.push_back(i);
`else
        cands.push_back(i);
`endif
      end
`ifdef MOVE_SEL_NEIGHBOR_EN
    if (cands.size() == 0 && b[112] == CELL_EMPTY) cands.push_back(112);
`endif
    foreach (cands[k]) begin
      sc = const5 ? 5 : row_own(b, cands[k], t);
      if (bm == 255 || sc > bs) begin bm = cands[k]; bs = sc; end
      cand_q.push_back(cands[k]);
    end
    exp_q.push_back('{move: bm, score: bs, starts: cands.size()});
  endfunction

  function automatic board_t rand_board(input int pct_empty);
    board_t b;
    for (int i = 0; i < 225; i++)
      b[i] = ($urandom_range(0, 99) < pct_empty) ? CELL_EMPTY
                                                 : cell_t'($urandom_range(1, 3));
    return b;
  endfunction

  // Scorer model: checks the trial board, answers 3 cycles after the start.
  int s_idx, s_ndiff, s_cnt;
  always begin
    @(negedge clk);
    if (sc_start) begin
      s_idx = -1; s_ndiff = 0; s_cnt = 0;
      for (int i = 0; i < 225; i++) begin
        if (sc_board[i] != ref_board[i]) begin s_ndiff++; s_idx = i; end
      end
      check("sc_changed_cells", s_ndiff, 1);
      check("sc_turn", sc_turn, ref_turn);
      if (s_idx >= 0) check("sc_stone", sc_board[s_idx], ref_turn ? 2 : 1);
      if (cand_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL issued_idx: got %0d, expected no scorer request", s_idx);
      end else check("issued_idx", s_idx, cand_q.pop_front());
      nstarts++;
      if (s_idx >= 0)
        for (int c = 0; c < 15; c++)
          if (sc_board[(s_idx/15)*15+c] == (sc_turn ? CELL_WHITE : CELL_BLACK)) s_cnt++;
      repeat (2) @(posedge clk);
      #1 mdl_fin = 1'b1; mdl_score = const5 ? 32'd5 : SW'(s_cnt);
      @(posedge clk);
      #1 mdl_fin = 1'b0;
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (finish) begin
      nfin++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_finish: got move %0d, expected no result", move);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_move", move, e.move);
        check("result_score", best, e.score);
        check("scorer_starts", nstarts, e.starts);
      end
    end
  end

  task automatic run_search(input board_t b, input bit t, input bit disturb,
                            output int lat);
    int f0;
    ref_board = b; ref_turn = t; nstarts = 0;
    ref_eval(b, t);
    f0 = nfin; lat = 0;
    @(posedge clk); #1 board = b; turn = t; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (disturb) begin
      stray_fin = 1'b1;                       // lands while DUT is in SCAN
      @(posedge clk); #1 stray_fin = 1'b0;
      board = rand_board(50); turn = ~t; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = 2;
    end
    @(negedge clk);
    check("busy_during_search", busy, 1);
    while (nfin == f0 && lat < 6000) begin @(posedge clk); lat++; end
    if (nfin == f0) begin
      n_chk++; n_fail++;
      $display("FAIL search_timeout: got no o_finish, expected one within 6000 cycles");
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_sc_start"}, sc_start, 0);
    check({tag, "_move"}, move, 255);
    check({tag, "_best"}, best, 0);
    check({tag, "_sc_turn"}, sc_turn, 0);
    check({tag, "_sc_board_empty"}, (sc_board == '0), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b;
    int lat, m1, f0, w, first;
    rst = 1'b1; start = 1'b0; board = '0; turn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Random positions.
    for (int k = 0; k < 4; k++) run_search(rand_board(8), 1'($urandom_range(0, 1)), 1'b0, lat);

    // Full board except 7 and 200, black to move.
    b = rand_board(0);
    b[7] = CELL_EMPTY; b[200] = CELL_EMPTY;
    run_search(b, 1'b0, 1'b0, lat);

    // Fully occupied: no requests, empty result, quick finish.
    run_search(rand_board(0), 1'b1, 1'b0, lat);
    check("full_board_latency_ok", (lat <= 230), 1);

    // Constant scorer: tie rule keeps lowest candidate.
    const5 = 1'b1;
    run_search(rand_board(10), 1'b0, 1'b0, lat);
    const5 = 1'b0;

    // Reset while waiting on the scorer; its late answer must be dropped.
    b = rand_board(10);
    ref_board = b; ref_turn = 1'b1; nstarts = 0;
    ref_eval(b, 1'b1);
    first = cand_q[0];
    cand_q.delete(); void'(exp_q.pop_back());
    cand_q.push_back(first);
    @(posedge clk); #1 board = b; turn = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!sc_start && w < 400);
    check("rst_test_saw_issue", sc_start, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_in_wait");
    f0 = nfin;
    repeat (300) @(posedge clk);
    check("rst_in_wait_no_finish", nfin - f0, 0);
    check("rst_in_wait_idle", busy, 0);

    // Undisturbed vs disturbed run on the same position.
    b = rand_board(8);
    for (int i = 0; i < 20; i++) b[i] = CELL_BLACK;
    run_search(b, 1'b1, 1'b0, lat);
    m1 = move;
    run_search(b, 1'b1, 1'b1, lat);
    check("disturbed_same_move", move, m1);

`ifdef MOVE_SEL_NEIGHBOR_EN
    run_search('0, 1'b0, 1'b0, lat);
    check("nbr_empty_center", move, 112);
    b = '0; b[0] = CELL_BLACK;
    run_search(b, 1'b1, 1'b0, lat);
    check("nbr_single_stone_starts", nstarts, 3);
`endif

    check("leftover_expected_results", exp_q.size(), 0);
    check("leftover_expected_issues", cand_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
